// File: rtl/ssd_scan_capture.sv
// Seven-segment scan monitor: synchronises the multiplexed ssd/dig bus, waits for
// each pattern to settle, and rebuilds the four displayed hex digits with blank/err/frame flags.
module ssd_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ssd,
  input  logic [3:0]  dig,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        err,
  output logic        frame_valid
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);
  // Raw bus levels meaning "nothing lit / nothing selected"; XOR normalises to active-high.
  localparam logic [6:0] SEG_IDLE = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0] DIG_IDLE = {4{DIG_ACTIVE_LOW}};

  logic [6:0]    r_ssd_s1, r_ssd_s2;
  logic [3:0]    r_dig_s1, r_dig_s2;
  logic [10:0]   r_prev;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_seen;

  logic [6:0]  w_seg;
  logic [3:0]  w_dig;
  logic [10:0] w_pat;
  logic        w_same;
  logic        w_commit;
  logic        w_onehot;
  logic [1:0]  w_idx;
  logic [3:0]  w_val;
  logic        w_valid;
  logic [3:0]  w_seen_nx;

  assign w_seg     = r_ssd_s2 ^ SEG_IDLE;
  assign w_dig     = r_dig_s2 ^ DIG_IDLE;
  assign w_pat     = {w_dig, w_seg};
  assign w_same    = (w_pat == r_prev);
  assign w_commit  = w_same && (r_cnt == CNT_PRE);
  assign w_onehot  = (w_dig != '0) && ((w_dig & (w_dig - 4'd1)) == '0);
  assign w_seen_nx = r_seen | w_dig;

  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_dig[i]) w_idx = 2'(i);
    end
  end

  always_comb begin
    w_valid = 1'b1;
    w_val   = '0;
    unique case (w_seg)
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssd_s1    <= SEG_IDLE;
      r_ssd_s2    <= SEG_IDLE;
      r_dig_s1    <= DIG_IDLE;
      r_dig_s2    <= DIG_IDLE;
      r_prev      <= '0;
      r_cnt       <= '0;
      r_seen      <= '0;
      digits      <= '0;
      blank       <= '1;
      err         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      r_ssd_s1 <= ssd;
      r_ssd_s2 <= r_ssd_s1;
      r_dig_s1 <= dig;
      r_dig_s2 <= r_dig_s1;
      r_prev   <= w_pat;

      if (!w_same)              r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);

      err         <= 1'b0;
      frame_valid <= 1'b0;

      if (w_commit && (w_dig != '0)) begin
        if (!w_onehot) begin
          err <= 1'b1;
        end else begin
          if (w_seg == '0) begin
            blank[w_idx] <= 1'b1;
          end else if (w_valid) begin
            digits[{w_idx, 2'b00} +: 4] <= w_val;
            blank[w_idx]                <= 1'b0;
          end else begin
            err <= 1'b1;
          end
          // Completing digit is not carried into the next frame.
          if (w_seen_nx == 4'hF) begin
            frame_valid <= 1'b1;
            r_seen      <= '0;
          end else begin
            r_seen <= w_seen_nx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Directed bench for ssd_scan_capture with default parameters (active-low bus).
module tb_ssd_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  ssd = 7'h7F;
  logic [3:0]  dig = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        err;
  logic        frame_valid;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int err_cnt = 0;
  int fv_cnt = 0;
  int fv_cyc = -1;

  ssd_scan_capture #(
    .STABLE_CYCLES(4),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ssd(ssd),
    .dig(dig),
    .digits(digits),
    .blank(blank),
    .err(err),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt = err_cnt + 1;
    if (frame_valid === 1'b1) begin
      fv_cnt = fv_cnt + 1;
      fv_cyc = cyc;
    end
  end

  // Called just after a posedge; the next posedge is edge 0 of the window.
  task automatic show(input logic [3:0] d, input logic [6:0] s, input int n, output int start);
    dig   = d;
    ssd   = s;
    start = cyc + 1;
    repeat (n) @(posedge clk);
    #1;
    dig = 4'hF;
    ssd = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [15:0] exp_d, input logic [3:0] exp_b);
    compared++;
    if (digits !== exp_d) begin
      mismatched++;
      $display("FAIL %s digits: got %h want %h", name, digits, exp_d);
    end
    compared++;
    if (blank !== exp_b) begin
      mismatched++;
      $display("FAIL %s blank: got %h want %h", name, blank, exp_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ssd = 7'($urandom);
      dig = 4'($urandom);
      @(negedge clk);
      compared++;
      if ({digits, blank, err, frame_valid} !== {16'h0000, 4'hF, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_hold: got %h/%h/%b/%b want 0000/f/0/0", digits, blank, err, frame_valid);
      end
    end
    ssd = 7'h7F;
    dig = 4'hF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_full_scan();
    int st;
    int e0;
    int f0;
    e0 = err_cnt;
    f0 = fv_cnt;
    show(4'hE, 7'h79, 8, st);
    show(4'hD, 7'h24, 8, st);
    show(4'hB, 7'h30, 8, st);
    compared++;
    if (fv_cnt !== f0) begin
      mismatched++;
      $display("FAIL scan_early_frame: got %0d pulses want 0", fv_cnt - f0);
    end
    show(4'h7, 7'h19, 8, st);
    check_state("full_scan", 16'h4321, 4'h0);
    compared++;
    if (fv_cnt - f0 !== 1) begin
      mismatched++;
      $display("FAIL scan_frame_count: got %0d want 1", fv_cnt - f0);
    end
    compared++;
    if (fv_cyc !== st + 6) begin
      mismatched++;
      $display("FAIL scan_frame_edge: got edge %0d want %0d", fv_cyc - st, 6);
    end
    compared++;
    if (err_cnt !== e0) begin
      mismatched++;
      $display("FAIL scan_err: got %0d pulses want 0", err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    int e0;
    int f0;
    e0 = err_cnt;
    f0 = fv_cnt;
    dig = 4'hE;
    ssd = 7'h00;
    repeat (4) @(posedge clk);
    #1;
    dig = 4'hF;
    ssd = 7'h7F;
    repeat (10) @(posedge clk);
    #1;
    check_state("glitch", 16'h4321, 4'h0);
    compared++;
    if ((err_cnt - e0) + (fv_cnt - f0) !== 0) begin
      mismatched++;
      $display("FAIL glitch_pulses: got err %0d frame %0d want 0/0", err_cnt - e0, fv_cnt - f0);
    end
  endtask

  task automatic test_invalid_overlap();
    int st;
    int e0;
    int f0;
    e0 = err_cnt;
    f0 = fv_cnt;
    show(4'hD, 7'h3F, 8, st);
    compared++;
    if (err_cnt - e0 !== 1) begin
      mismatched++;
      $display("FAIL invalid_err: got %0d pulses want 1", err_cnt - e0);
    end
    check_state("invalid", 16'h4321, 4'h0);
    show(4'hC, 7'h79, 8, st);
    compared++;
    if (err_cnt - e0 !== 2) begin
      mismatched++;
      $display("FAIL overlap_err: got %0d pulses want 2", err_cnt - e0);
    end
    check_state("overlap", 16'h4321, 4'h0);
    compared++;
    if (fv_cnt !== f0) begin
      mismatched++;
      $display("FAIL overlap_frame: got %0d pulses want 0", fv_cnt - f0);
    end
  endtask

  task automatic test_blank();
    int st;
    int e0;
    int f0;
    e0 = err_cnt;
    f0 = fv_cnt;
    show(4'hB, 7'h7F, 8, st);
    check_state("blank_set", 16'h4321, 4'h4);
    show(4'hB, 7'h08, 8, st);
    check_state("blank_clear", 16'h4A21, 4'h0);
    compared++;
    if ((err_cnt - e0) + (fv_cnt - f0) !== 0) begin
      mismatched++;
      $display("FAIL blank_pulses: got err %0d frame %0d want 0/0", err_cnt - e0, fv_cnt - f0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int st;
    int f0;
    show(4'hE, 7'h12, 8, st);
    show(4'hD, 7'h02, 8, st);
    check_state("pre_reset", 16'h4A65, 4'h0);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({digits, blank, err, frame_valid} !== {16'h0000, 4'hF, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_reset: got %h/%h/%b/%b want 0000/f/0/0", digits, blank, err, frame_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    f0 = fv_cnt;
    show(4'hB, 7'h78, 8, st);
    show(4'h7, 7'h0E, 8, st);
    show(4'hE, 7'h46, 8, st);
    compared++;
    if (fv_cnt !== f0) begin
      mismatched++;
      $display("FAIL post_reset_early_frame: got %0d pulses want 0", fv_cnt - f0);
    end
    show(4'hD, 7'h21, 8, st);
    compared++;
    if (fv_cnt - f0 !== 1 || fv_cyc !== st + 6) begin
      mismatched++;
      $display("FAIL post_reset_frame: got %0d pulses at edge %0d want 1 at 6", fv_cnt - f0, fv_cyc - st);
    end
    check_state("post_reset_scan", 16'hF7DC, 4'h0);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_glitch();
    test_invalid_overlap();
    test_blank();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ssd_scan_capture.md
# ssd_scan_capture

Reader for the lock's multiplexed seven-segment output. It samples the time-multiplexed `ssd`/`dig` bus that the lock top drives and rebuilds the four displayed hex digits into registers. It also reports blank digits, bus errors and completed scan frames. It sits beside the lock top as an on-chip display monitor and self-check path, so digit state can be read without decoding the display in the bench.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive equal samples a pattern must hold before commit; legal range 1..255.
- `SEG_ACTIVE_LOW`, default 1: 1 = a segment is lit when its `ssd` bit is 0.
- `DIG_ACTIVE_LOW`, default 1: 1 = a digit is selected when its `dig` bit is 0.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  input  1  sole clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `ssd`  input  7  segment bus, bit0 = a … bit6 = g; asynchronous to `clk`.
- `dig`  input  4  digit enables, bit i = digit i; asynchronous to `clk`.
- `digits`  output  16  captured values, digit i in `[4i+3:4i]`.
- `blank`  output  4  bit i = 1 when digit i was last committed with all segments off.
- `err`  output  1  one-cycle pulse on a bad commit.
- `frame_valid`  output  1  one-cycle pulse when all four digits have been committed since the last frame.

## Operation
- **Synchronisation.** `ssd` and `dig` each pass through a 2-flop synchroniser. Both are then normalised to active-high per the parameters, giving `s_seg` and `s_dig`.
- **Stability tracking.** `p` holds the previous `{s_dig, s_seg}`.
  - The counter `cnt` clears to 0 when `{s_dig, s_seg}` ≠ `p`.
  - Otherwise `cnt` increments and saturates at `STABLE_CYCLES`.
  - Commit happens on the edge where `cnt` goes from `STABLE_CYCLES-1` to `STABLE_CYCLES`. This is exactly one commit per stable pattern; no re-commit until the pattern changes.
- **Commit rules by `s_dig`:**
  - 4'b0000 (inter-digit blanking): no action.
  - More than one bit set: `err` pulses; no other state changes.
  - One-hot, index i, with `s_seg` = 0: `blank[i]` <= 1, `digits[i]` holds, `seen[i]` <= 1.
  - One-hot, index i, with `s_seg` in the decode table: `digits[i]` <= value, `blank[i]` <= 0, `seen[i]` <= 1.
  - One-hot, index i, with any other `s_seg`: `err` pulses, `digits[i]`/`blank[i]` hold, `seen[i]` <= 1.
- **Decode table** (gfedcba, active-high hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. All other codes are invalid.
- **Frame tracking.** When a commit makes `seen | new_bit` = 4'b1111, `frame_valid` pulses on that edge and `seen` <= 0 (the new bit is not retained). Repeated commits of an already-seen digit only overwrite its value.

## Timing
- **Reset values.** All outputs and state are set asynchronously on `rst_n` low:
  - `digits` = 16'h0000, `blank` = 4'hF, `err` = 0, `frame_valid` = 0.
  - `seen` = 0, `cnt` = 0.
  - Synchroniser and `p` flops hold the raw inactive pattern: all digits deselected, all segments off.
- **Release.** `rst_n` deasserts synchronously to `clk` in the bench; the first commit needs a full stability window after release.
- **Latency.** Number edges from 0, the first edge that samples a new raw pattern.
  - The pattern must be sampled on edges 0..`STABLE_CYCLES` (`STABLE_CYCLES`+1 samples).
  - `digits`/`blank`/`err`/`frame_valid` update on edge `STABLE_CYCLES`+2. With default parameters this is edge 6.
  - A pattern sampled on fewer edges than that never commits.
- **Pulse width.** `err` and `frame_valid` are registered and high for exactly one cycle. They can be high in the same cycle when a bad pattern completes a frame.
- **Reset mid-operation.** A partial frame is discarded; a full four-digit scan is required after reset before `frame_valid`.
- **Counter width.** `cnt` is clog2(`STABLE_CYCLES`+1) bits and never wraps.

## Test plan
All scenarios use default parameters. "Raw" values are the active-low bus levels on `ssd`/`dig`.
- **Reset.** Hold `rst_n`=0 with random `ssd`/`dig` -> `digits`=0000, `blank`=F, `err`=0, `frame_valid`=0 throughout.
- **Full scan.** Show 1, 2, 3, 4 on digits 0..3 (raw `dig`=E, D, B, 7; raw `ssd`=~06, ~5B, ~4F, ~66). Hold each for 8 cycles with 2-cycle gaps of `dig`=F. Required: `digits`=16'h4321 and `blank`=0; one `frame_valid` pulse on edge 6 of digit 3's window; no `err`.
- **Glitch rejection.** Show digit 0 = 8 for exactly 4 sampled cycles, then `dig`=F -> no change, no pulses.
- **Invalid and overlap.**
  - Digit 1 with `ssd`=~40 -> one `err` pulse; `digits[7:4]` unchanged.
  - `dig`=4'b1100 held 8 cycles -> one `err` pulse; nothing else changes.
- **Blank digit.** Digit 2 with `ssd`=7F raw (all off) -> `blank[2]`=1 and `digits[11:8]` holds. A later commit of "A" (~77) -> `digits[11:8]`=A and `blank[2]`=0.
- **Reset mid-frame.** Commit digits 0 and 1, pulse `rst_n` low for 1 cycle -> all outputs return to reset values immediately. Then scan digits 2, 3, 0, 1 -> `frame_valid` only after digit 1 commits.
